axi4_slave_write_arbiter: RTL and testbench

AXI4_SLAVE_WRITE_ARBITER -- requirements
Module: axi4_slave_write_arbiter

---
 rtl/axi4_xbar_pkg.sv | 17 +
 rtl/axi4_index_fifo.sv | 68 ++++++
 rtl/axi4_slave_write_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_axi4_slave_write_arbiter.sv | 421 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi4_xbar_pkg.sv
// Shared parameters and types for the AXI4 crossbar slave-side write path.
// Widths here act as defaults for the arbiter and its ordering FIFO.
package axi4_xbar_pkg;

   localparam int MASTER_NUM   = 4;
   localparam int W_ID_LEN     = 4;
   localparam int ADDR_WIDTH   = 32;
   localparam int DATA_WIDTH   = 64;
   localparam int W_BUF_DEPTH  = 2;
   localparam int EXTRA_ID_LEN = $clog2(MASTER_NUM);

   typedef enum logic {
      AW_IDLE = 1'b0,
      AW_BUSY = 1'b1
   } aw_state_e;

endpackage

// File: rtl/axi4_index_fifo.sv
// Small FIFO of granted master indices.
// Its order decides which master owns the W channel.
module axi4_index_fifo
   import axi4_xbar_pkg::*;
#(
   parameter int WIDTH = EXTRA_ID_LEN,
   parameter int DEPTH = W_BUF_DEPTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             empty,
   output logic             full
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic [CW-1:0]    count;
   logic             do_push;
   logic             do_pop;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      if (p == PW'(DEPTH - 1)) begin
         return '0;
      end
      return p + PW'(1);
   endfunction

   assign empty   = (count == '0);
   assign full    = (count == CW'(DEPTH));
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= din;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= ptr_inc(wr_ptr);
         end
         if (do_pop) begin
            rd_ptr <= ptr_inc(rd_ptr);
         end
         unique case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/axi4_slave_write_arbiter.sv
// Round-robin AW arbiter for one slave port; W follows AW grant order,
// B is routed back by the master index carried in the upper ID bits.
module axi4_slave_write_arbiter #(
   parameter int MASTER_NUM  = axi4_xbar_pkg::MASTER_NUM,
   parameter int W_ID_LEN    = axi4_xbar_pkg::W_ID_LEN,
   parameter int ADDR_WIDTH  = axi4_xbar_pkg::ADDR_WIDTH,
   parameter int DATA_WIDTH  = axi4_xbar_pkg::DATA_WIDTH,
   parameter int W_BUF_DEPTH = axi4_xbar_pkg::W_BUF_DEPTH,
   localparam int EXTRA_ID_LEN = (MASTER_NUM > 1) ? $clog2(MASTER_NUM) : 1,
   localparam int SID_WIDTH    = EXTRA_ID_LEN + W_ID_LEN,
   localparam int STRB_WIDTH   = DATA_WIDTH / 8
) (
   input  logic                                  ACLK,
   input  logic                                  ARESET,

   input  logic [MASTER_NUM-1:0][W_ID_LEN-1:0]   m_AWID,
   input  logic [MASTER_NUM-1:0][ADDR_WIDTH-1:0] m_AWADDR,
   input  logic [MASTER_NUM-1:0][7:0]            m_AWLEN,
   input  logic [MASTER_NUM-1:0][2:0]            m_AWSIZE,
   input  logic [MASTER_NUM-1:0][1:0]            m_AWBURST,
   input  logic [MASTER_NUM-1:0]                 m_AWLOCK,
   input  logic [MASTER_NUM-1:0][3:0]            m_AWCACHE,
   input  logic [MASTER_NUM-1:0][2:0]            m_AWPROT,
   input  logic [MASTER_NUM-1:0]                 m_AWVALID,
   output logic [MASTER_NUM-1:0]                 m_AWREADY,

   input  logic [MASTER_NUM-1:0][DATA_WIDTH-1:0] m_WDATA,
   input  logic [MASTER_NUM-1:0][STRB_WIDTH-1:0] m_WSTRB,
   input  logic [MASTER_NUM-1:0]                 m_WLAST,
   input  logic [MASTER_NUM-1:0]                 m_WVALID,
   output logic [MASTER_NUM-1:0]                 m_WREADY,

   output logic [MASTER_NUM-1:0][W_ID_LEN-1:0]   m_BID,
   output logic [MASTER_NUM-1:0][1:0]            m_BRESP,
   output logic [MASTER_NUM-1:0]                 m_BVALID,
   input  logic [MASTER_NUM-1:0]                 m_BREADY,

   output logic [SID_WIDTH-1:0]                  s_AWID,
   output logic [ADDR_WIDTH-1:0]                 s_AWADDR,
   output logic [7:0]                            s_AWLEN,
   output logic [2:0]                            s_AWSIZE,
   output logic [1:0]                            s_AWBURST,
   output logic                                  s_AWLOCK,
   output logic [3:0]                            s_AWCACHE,
   output logic [2:0]                            s_AWPROT,
   output logic                                  s_AWVALID,
   input  logic                                  s_AWREADY,

   output logic [DATA_WIDTH-1:0]                 s_WDATA,
   output logic [STRB_WIDTH-1:0]                 s_WSTRB,
   output logic                                  s_WLAST,
   output logic                                  s_WVALID,
   input  logic                                  s_WREADY,

   input  logic [SID_WIDTH-1:0]                  s_BID,
   input  logic [1:0]                            s_BRESP,
   input  logic                                  s_BVALID,
   output logic                                  s_BREADY
);

   import axi4_xbar_pkg::*;

   aw_state_e               state;
   aw_state_e               state_nx;
   logic [EXTRA_ID_LEN-1:0] sel;
   logic [EXTRA_ID_LEN-1:0] last_grant;
   logic [EXTRA_ID_LEN-1:0] winner;
   logic [EXTRA_ID_LEN-1:0] cand;
   logic                    found;
   logic                    grant;
   logic                    aw_push;

   logic [EXTRA_ID_LEN-1:0] head;
   logic                    fifo_empty;
   logic                    fifo_full;
   logic                    w_pop;

   logic [EXTRA_ID_LEN-1:0] bidx;

   // Search starts one past the last winner so every requester gets a turn.
   always_comb begin
      winner = last_grant;
      found  = 1'b0;
      cand   = '0;
      for (int i = 1; i <= MASTER_NUM; i++) begin
         cand = EXTRA_ID_LEN'((int'(last_grant) + i) % MASTER_NUM);
         if (!found && m_AWVALID[cand]) begin
            winner = cand;
            found  = 1'b1;
         end
      end
   end

   assign grant   = (state == AW_IDLE) && found && !fifo_full;
   assign aw_push = (state == AW_BUSY) && s_AWVALID && s_AWREADY;

   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         state      <= AW_IDLE;
         sel        <= '0;
         last_grant <= EXTRA_ID_LEN'(MASTER_NUM - 1);
      end else begin
         state <= state_nx;
         if (grant) begin
            sel <= winner;
         end
         if (aw_push) begin
            last_grant <= sel;
         end
      end
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         AW_IDLE: if (grant)   state_nx = AW_BUSY;
         AW_BUSY: if (aw_push) state_nx = AW_IDLE;
         default:              state_nx = AW_IDLE;
      endcase
   end

   // The grant is frozen in sel, so other requests cannot steal it mid-offer.
   always_comb begin
      s_AWVALID = 1'b0;
      m_AWREADY = '0;
      if (state == AW_BUSY) begin
         s_AWVALID      = m_AWVALID[sel];
         m_AWREADY[sel] = s_AWREADY;
      end
   end

   assign s_AWID    = {sel, m_AWID[sel]};
   assign s_AWADDR  = m_AWADDR[sel];
   assign s_AWLEN   = m_AWLEN[sel];
   assign s_AWSIZE  = m_AWSIZE[sel];
   assign s_AWBURST = m_AWBURST[sel];
   assign s_AWLOCK  = m_AWLOCK[sel];
   assign s_AWCACHE = m_AWCACHE[sel];
   assign s_AWPROT  = m_AWPROT[sel];

   axi4_index_fifo #(
      .WIDTH (EXTRA_ID_LEN),
      .DEPTH (W_BUF_DEPTH)
   ) u_w_order (
      .clk   (ACLK),
      .rst   (ARESET),
      .push  (aw_push),
      .din   (sel),
      .pop   (w_pop),
      .dout  (head),
      .empty (fifo_empty),
      .full  (fifo_full)
   );

   assign s_WDATA = m_WDATA[head];
   assign s_WSTRB = m_WSTRB[head];
   assign s_WLAST = m_WLAST[head];

   // Write data arriving ahead of its address waits until the AW is ordered.
   always_comb begin
      s_WVALID = 1'b0;
      m_WREADY = '0;
      if (!fifo_empty) begin
         s_WVALID       = m_WVALID[head];
         m_WREADY[head] = s_WREADY;
      end
   end

   assign w_pop = s_WVALID && s_WREADY && s_WLAST;

   assign bidx = s_BID[SID_WIDTH-1 -: EXTRA_ID_LEN];

   always_comb begin
      m_BVALID = '0;
      m_BID    = '0;
      m_BRESP  = '0;
      s_BREADY = 1'b0;
      if (int'(bidx) < MASTER_NUM) begin
         m_BVALID[bidx] = s_BVALID;
         m_BID[bidx]    = s_BID[W_ID_LEN-1:0];
         m_BRESP[bidx]  = s_BRESP;
         s_BREADY       = m_BREADY[bidx];
      end
   end

endmodule

// File: tb/tb_axi4_slave_write_arbiter.sv
// Scoreboard bench for the slave write arbiter: AW and W beats at the
// slave port are checked in order against expectations queued by stimulus.
module tb_axi4_slave_write_arbiter;

   localparam int MN  = 4;
   localparam int IW  = 4;
   localparam int AWD = 32;
   localparam int DW  = 64;
   localparam int SW  = 6;

   logic                  ACLK;
   logic                  ARESET;
   logic [MN-1:0][IW-1:0] m_AWID;
   logic [MN-1:0][AWD-1:0] m_AWADDR;
   logic [MN-1:0][7:0]    m_AWLEN;
   logic [MN-1:0][2:0]    m_AWSIZE;
   logic [MN-1:0][1:0]    m_AWBURST;
   logic [MN-1:0]         m_AWLOCK;
   logic [MN-1:0][3:0]    m_AWCACHE;
   logic [MN-1:0][2:0]    m_AWPROT;
   logic [MN-1:0]         m_AWVALID;
   logic [MN-1:0]         m_AWREADY;
   logic [MN-1:0][DW-1:0] m_WDATA;
   logic [MN-1:0][7:0]    m_WSTRB;
   logic [MN-1:0]         m_WLAST;
   logic [MN-1:0]         m_WVALID;
   logic [MN-1:0]         m_WREADY;
   logic [MN-1:0][IW-1:0] m_BID;
   logic [MN-1:0][1:0]    m_BRESP;
   logic [MN-1:0]         m_BVALID;
   logic [MN-1:0]         m_BREADY;
   logic [SW-1:0]         s_AWID;
   logic [AWD-1:0]        s_AWADDR;
   logic [7:0]            s_AWLEN;
   logic [2:0]            s_AWSIZE;
   logic [1:0]            s_AWBURST;
   logic                  s_AWLOCK;
   logic [3:0]            s_AWCACHE;
   logic [2:0]            s_AWPROT;
   logic                  s_AWVALID;
   logic                  s_AWREADY;
   logic [DW-1:0]         s_WDATA;
   logic [7:0]            s_WSTRB;
   logic                  s_WLAST;
   logic                  s_WVALID;
   logic                  s_WREADY;
   logic [SW-1:0]         s_BID;
   logic [1:0]            s_BRESP;
   logic                  s_BVALID;
   logic                  s_BREADY;

   axi4_slave_write_arbiter #(
      .MASTER_NUM  (MN),
      .W_ID_LEN    (IW),
      .ADDR_WIDTH  (AWD),
      .DATA_WIDTH  (DW),
      .W_BUF_DEPTH (2)
   ) dut (
      .ACLK      (ACLK),
      .ARESET    (ARESET),
      .m_AWID    (m_AWID),
      .m_AWADDR  (m_AWADDR),
      .m_AWLEN   (m_AWLEN),
      .m_AWSIZE  (m_AWSIZE),
      .m_AWBURST (m_AWBURST),
      .m_AWLOCK  (m_AWLOCK),
      .m_AWCACHE (m_AWCACHE),
      .m_AWPROT  (m_AWPROT),
      .m_AWVALID (m_AWVALID),
      .m_AWREADY (m_AWREADY),
      .m_WDATA   (m_WDATA),
      .m_WSTRB   (m_WSTRB),
      .m_WLAST   (m_WLAST),
      .m_WVALID  (m_WVALID),
      .m_WREADY  (m_WREADY),
      .m_BID     (m_BID),
      .m_BRESP   (m_BRESP),
      .m_BVALID  (m_BVALID),
      .m_BREADY  (m_BREADY),
      .s_AWID    (s_AWID),
      .s_AWADDR  (s_AWADDR),
      .s_AWLEN   (s_AWLEN),
      .s_AWSIZE  (s_AWSIZE),
      .s_AWBURST (s_AWBURST),
      .s_AWLOCK  (s_AWLOCK),
      .s_AWCACHE (s_AWCACHE),
      .s_AWPROT  (s_AWPROT),
      .s_AWVALID (s_AWVALID),
      .s_AWREADY (s_AWREADY),
      .s_WDATA   (s_WDATA),
      .s_WSTRB   (s_WSTRB),
      .s_WLAST   (s_WLAST),
      .s_WVALID  (s_WVALID),
      .s_WREADY  (s_WREADY),
      .s_BID     (s_BID),
      .s_BRESP   (s_BRESP),
      .s_BVALID  (s_BVALID),
      .s_BREADY  (s_BREADY)
   );

   initial ACLK = 1'b0;
   always #5 ACLK = ~ACLK;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   logic [45:0] aw_q [$];
   logic [64:0] w_q  [$];
   int          aw_cyc [$];
   int          wrem [MN];

   logic [45:0] aw_want;
   logic [45:0] aw_got;
   logic [64:0] w_want;
   logic [64:0] w_got;

   logic          smp_awvalid;
   logic          smp_wvalid;
   logic [MN-1:0] smp_awready;
   logic [MN-1:0] smp_wready;

   always @(posedge ACLK) cyc <= cyc + 1;

   // Monitor: every slave-side handshake must match the oldest expectation.
   always @(negedge ACLK) begin
      if (!ARESET && s_AWVALID && s_AWREADY) begin
         aw_cyc.push_back(cyc);
         checks++;
         aw_got = {s_AWID, s_AWADDR, s_AWLEN};
         if (aw_q.size() == 0) begin
            errors++;
            $display("FAIL aw_unexpected: got %0h, none expected", aw_got);
         end else begin
            aw_want = aw_q.pop_front();
            if (aw_got !== aw_want) begin
               errors++;
               $display("FAIL aw_order: got %0h expected %0h", aw_got, aw_want);
            end
         end
      end
      if (!ARESET && s_WVALID && s_WREADY) begin
         checks++;
         w_got = {s_WLAST, s_WDATA};
         if (w_q.size() == 0) begin
            errors++;
            $display("FAIL w_unexpected: got %0h, none expected", w_got);
         end else begin
            w_want = w_q.pop_front();
            if (w_got !== w_want) begin
               errors++;
               $display("FAIL w_order: got %0h expected %0h", w_got, w_want);
            end
         end
      end
   end

   task automatic check(input string name, input logic [63:0] act,
                        input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // One clock of master behaviour: drop AWVALID after acceptance and
   // advance each master's W burst on every accepted beat.
   task automatic step();
      logic [MN-1:0] aw_hs;
      logic [MN-1:0] w_hs;
      @(negedge ACLK);
      aw_hs = ARESET ? '0 : (m_AWVALID & m_AWREADY);
      w_hs  = ARESET ? '0 : (m_WVALID & m_WREADY);
      smp_awvalid = s_AWVALID;
      smp_wvalid  = s_WVALID;
      smp_awready = m_AWREADY;
      smp_wready  = m_WREADY;
      @(posedge ACLK);
      #1;
      for (int i = 0; i < MN; i++) begin
         if (aw_hs[i]) m_AWVALID[i] = 1'b0;
         if (w_hs[i]) begin
            wrem[i]--;
            m_WDATA[i] = m_WDATA[i] + 64'd1;
            m_WLAST[i] = (wrem[i] == 1);
            if (wrem[i] <= 0) m_WVALID[i] = 1'b0;
         end
      end
   endtask

   task automatic start_aw(input int m, input logic [3:0] id,
                           input logic [31:0] addr, input logic [7:0] len);
      m_AWID[m]    = id;
      m_AWADDR[m]  = addr;
      m_AWLEN[m]   = len;
      m_AWVALID[m] = 1'b1;
   endtask

   task automatic exp_aw(input int m, input logic [3:0] id,
                         input logic [31:0] addr, input logic [7:0] len);
      logic [1:0] mm;
      mm = 2'(m);
      aw_q.push_back({mm, id, addr, len});
   endtask

   task automatic start_w(input int m, input int beats, input logic [63:0] base);
      m_WDATA[m]  = base;
      m_WSTRB[m]  = 8'hFF;
      m_WLAST[m]  = (beats == 1);
      m_WVALID[m] = 1'b1;
      wrem[m]     = beats;
   endtask

   task automatic exp_w(input int beats, input logic [63:0] base);
      for (int b = 0; b < beats; b++) begin
         w_q.push_back({(b == beats - 1), base + 64'(b)});
      end
   endtask

   task automatic wait_drain(input int budget, input string name);
      int n;
      n = 0;
      while ((aw_q.size() != 0 || w_q.size() != 0) && n < budget) begin
         step();
         n++;
      end
      checks++;
      if (aw_q.size() != 0 || w_q.size() != 0) begin
         errors++;
         $display("FAIL %s: timeout with %0d aw and %0d w pending, required 0",
                  name, aw_q.size(), w_q.size());
         aw_q.delete();
         w_q.delete();
      end
   endtask

   initial begin
      int n;
      ARESET    = 1'b1;
      m_AWID    = '0;
      m_AWADDR  = '0;
      m_AWLEN   = '0;
      m_AWSIZE  = {MN{3'd3}};
      m_AWBURST = {MN{2'b01}};
      m_AWLOCK  = '0;
      m_AWCACHE = '0;
      m_AWPROT  = '0;
      m_WDATA   = '0;
      m_WSTRB   = '0;
      m_WLAST   = '1;
      m_BREADY  = '0;
      s_BID     = '0;
      s_BRESP   = '0;
      s_BVALID  = 1'b0;
      for (int i = 0; i < MN; i++) wrem[i] = 0;
      // Requests and readies active during reset must all be ignored.
      m_AWVALID = '1;
      m_WVALID  = '1;
      s_AWREADY = 1'b1;
      s_WREADY  = 1'b1;
      repeat (3) step();
      check("rst_s_awvalid", 64'(smp_awvalid), 64'd0);
      check("rst_s_wvalid", 64'(smp_wvalid), 64'd0);
      check("rst_m_awready", 64'(smp_awready), 64'd0);
      check("rst_m_wready", 64'(smp_wready), 64'd0);
      m_AWVALID = '0;
      m_WVALID  = '0;
      m_WLAST   = '0;
      ARESET    = 1'b0;

      // All four request together: grants 0,1,2,3 two cycles apart.
      aw_cyc.delete();
      for (int i = 0; i < MN; i++) begin
         start_aw(i, 4'(5 + i), 32'h1000 * (i + 1), 8'd0);
         exp_aw(i, 4'(5 + i), 32'h1000 * (i + 1), 8'd0);
         start_w(i, 1, 64'h100 * (i + 1));
         exp_w(1, 64'h100 * (i + 1));
      end
      wait_drain(60, "rr_drain");
      check("rr_grant_count", 64'(aw_cyc.size()), 64'd4);
      for (int i = 1; i < aw_cyc.size(); i++) begin
         check("rr_grant_spacing", 64'(aw_cyc[i] - aw_cyc[i-1]), 64'd2);
      end

      // Four-beat burst from m2; pop only on WLAST, FIFO empty afterwards.
      start_aw(2, 4'hC, 32'h2000_0040, 8'd3);
      exp_aw(2, 4'hC, 32'h2000_0040, 8'd3);
      start_w(2, 4, 64'hA0);
      exp_w(4, 64'hA0);
      wait_drain(40, "burst_drain");
      m_WVALID[2] = 1'b1;
      m_WLAST[2]  = 1'b1;
      step();
      check("burst_fifo_empty_wready", 64'(smp_wready), 64'd0);
      check("burst_fifo_empty_wvalid", 64'(smp_wvalid), 64'd0);
      m_WVALID[2] = 1'b0;

      // W ahead of AW from m1 must stall.
      start_w(1, 1, 64'h5151);
      exp_w(1, 64'h5151);
      repeat (3) begin
         step();
         check("w_before_aw_wready", 64'(smp_wready[1]), 64'd0);
      end
      start_aw(1, 4'h3, 32'h3000, 8'd0);
      exp_aw(1, 4'h3, 32'h3000, 8'd0);
      wait_drain(30, "w_first_drain");

      // Two outstanding bursts fill the FIFO; the third requester waits.
      // Last grant was m1, so search order is 2,3,0,1.
      s_WREADY = 1'b0;
      start_aw(0, 4'h1, 32'h4000, 8'd0);
      start_aw(1, 4'h2, 32'h4100, 8'd0);
      start_aw(3, 4'h4, 32'h4300, 8'd0);
      start_w(0, 1, 64'h4000);
      start_w(1, 1, 64'h4100);
      start_w(3, 1, 64'h4300);
      exp_aw(3, 4'h4, 32'h4300, 8'd0);
      exp_aw(0, 4'h1, 32'h4000, 8'd0);
      exp_aw(1, 4'h2, 32'h4100, 8'd0);
      exp_w(1, 64'h4300);
      exp_w(1, 64'h4000);
      exp_w(1, 64'h4100);
      n = 0;
      while (aw_q.size() > 1 && n < 30) begin
         step();
         n++;
      end
      check("full_two_grants", 64'(aw_q.size()), 64'd1);
      repeat (3) begin
         step();
         check("full_no_s_awvalid", 64'(smp_awvalid), 64'd0);
         check("full_no_m_awready", 64'(smp_awready), 64'd0);
      end
      s_WREADY = 1'b1;
      wait_drain(30, "full_drain");

      // B routing by upper ID bits.
      m_BREADY = 4'b0111;
      s_BID    = 6'b11_0101;
      s_BRESP  = 2'b10;
      s_BVALID = 1'b1;
      @(negedge ACLK);
      check("b_valid_m3", 64'(m_BVALID), 64'b1000);
      check("b_id_m3", 64'(m_BID[3]), 64'h5);
      check("b_resp_m3", 64'(m_BRESP[3]), 64'h2);
      check("b_stall_m3", 64'(s_BREADY), 64'd0);
      @(posedge ACLK);
      #1;
      m_BREADY = 4'b1000;
      @(negedge ACLK);
      check("b_ready_m3", 64'(s_BREADY), 64'd1);
      @(posedge ACLK);
      #1;
      m_BREADY = 4'b0001;
      s_BID    = 6'b00_1111;
      s_BRESP  = 2'b00;
      @(negedge ACLK);
      check("b_valid_m0", 64'(m_BVALID), 64'b0001);
      check("b_id_m0", 64'(m_BID[0]), 64'hF);
      check("b_ready_m0", 64'(s_BREADY), 64'd1);
      @(posedge ACLK);
      #1;
      s_BVALID = 1'b0;
      @(negedge ACLK);
      check("b_idle", 64'(m_BVALID), 64'd0);
      @(posedge ACLK);
      #1;
      m_BREADY = '0;

      // Reset while AW_BUSY with one queued burst discards everything.
      s_WREADY  = 1'b0;
      s_AWREADY = 1'b1;
      start_aw(1, 4'h7, 32'h5000, 8'd0);
      exp_aw(1, 4'h7, 32'h5000, 8'd0);
      start_w(1, 1, 64'h5555);
      n = 0;
      while (aw_q.size() != 0 && n < 20) begin
         step();
         n++;
      end
      check("pre_rst_grant", 64'(aw_q.size()), 64'd0);
      s_AWREADY = 1'b0;
      start_aw(2, 4'h9, 32'h5200, 8'd0);
      step();
      step();
      check("pre_rst_busy", 64'(smp_awvalid), 64'd1);
      ARESET = 1'b1;
      step();
      ARESET    = 1'b0;
      s_WREADY  = 1'b1;
      s_AWREADY = 1'b1;
      start_aw(0, 4'hB, 32'h5400, 8'd0);
      start_w(0, 1, 64'h6000);
      start_w(2, 1, 64'h6200);
      exp_aw(0, 4'hB, 32'h5400, 8'd0);
      exp_aw(2, 4'h9, 32'h5200, 8'd0);
      exp_w(1, 64'h6000);
      exp_w(1, 64'h6200);
      step();
      check("post_rst_s_awvalid", 64'(smp_awvalid), 64'd0);
      check("post_rst_s_wvalid", 64'(smp_wvalid), 64'd0);
      check("post_rst_m_wready", 64'(smp_wready), 64'd0);
      m_WVALID[1] = 1'b0;
      wrem[1]     = 0;
      wait_drain(30, "post_rst_drain");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      errors++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
